hilo_md_sequencer: RTL and testbench

//  Multi-cycle multiply/divide sequencer owning the HI/LO register pair of the MIPS core.

---
 rtl/hilo_md_sequencer.sv | 165 ++++++++++++++++
 tb/tb_hilo_md_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/hilo_md_sequencer.sv
// Iterative radix-2 multiply/divide sequencer that owns the MIPS HI/LO pair.
// Handles MTHI/MTLO writes and stalls the core while a running op conflicts with its request.
module hilo_md_sequencer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              wr_hi,
  input  logic              wr_lo,
  input  logic [DATA_W-1:0] wd,
  input  logic              rd_req,
  output logic [DATA_W-1:0] hi_q,
  output logic [DATA_W-1:0] lo_q,
  output logic              busy,
  output logic              done,
  output logic              dbz,
  output logic              stall
);

  localparam int unsigned ACC_W = 2 * DATA_W;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [DATA_W-1:0]   opnd_q, opnd_d;
  logic                is_div_q, is_div_d;
  logic                sign_a_q, sign_a_d;
  logic                neg_q, neg_d;
  logic                zdiv_q, zdiv_d;
  logic [DATA_W-1:0]   hi_d, lo_d;
  logic                busy_d, done_d, dbz_d;

  logic [DATA_W-1:0]   mag_a, mag_b;
  logic [DATA_W:0]     mul_sum;
  logic [ACC_W-1:0]    mul_next;
  logic [DATA_W:0]     rem_sh;
  logic                div_ge;
  logic [DATA_W-1:0]   div_sub;
  logic [ACC_W-1:0]    div_next;
  logic [ACC_W-1:0]    prod_neg;
  logic [DATA_W-1:0]   quo_neg, rem_neg;

  // Signed ops iterate on magnitudes; signs are restored in FIXUP.
  assign mag_a = (op[0] && a[DATA_W-1]) ? DATA_W'(~a + 1'b1) : a;
  assign mag_b = (op[0] && b[DATA_W-1]) ? DATA_W'(~b + 1'b1) : b;

  // Shift-add multiply step: {acc_hi + (lsb ? mcand : 0), acc_lo} >> 1
  assign mul_sum  = {1'b0, acc_q[ACC_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opnd_q} : {(DATA_W+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[DATA_W-1:1]};

  // Restoring divide step: remainder in the upper half, quotient bits shift into the lower half.
  assign rem_sh   = {acc_q[ACC_W-1:DATA_W], acc_q[DATA_W-1]};
  assign div_ge   = rem_sh >= {1'b0, opnd_q};
  assign div_sub  = rem_sh[DATA_W-1:0] - opnd_q;
  assign div_next = {(div_ge ? div_sub : rem_sh[DATA_W-1:0]), acc_q[DATA_W-2:0], div_ge};

  assign prod_neg = ACC_W'(~acc_q + 1'b1);
  assign quo_neg  = DATA_W'(~acc_q[DATA_W-1:0] + 1'b1);
  assign rem_neg  = DATA_W'(~acc_q[ACC_W-1:DATA_W] + 1'b1);

  assign stall = busy & (start | rd_req | wr_hi | wr_lo);

  // Next-state, datapath and output decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    sign_a_d = sign_a_q;
    neg_d    = neg_q;
    zdiv_d   = zdiv_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (wr_hi) hi_d = wd;
        if (wr_lo) lo_d = wd;
        if (start) begin
          state_d  = S_CALC;
          cnt_d    = '0;
          is_div_d = op[1];
          sign_a_d = op[0] & a[DATA_W-1];
          neg_d    = op[0] & (a[DATA_W-1] ^ b[DATA_W-1]);
          zdiv_d   = 1'b0;
          if (op[1]) begin
            opnd_d = mag_b;
            acc_d  = {{DATA_W{1'b0}}, mag_a};
            if (b == '0) begin
              // Divide by zero skips iteration: remainder = |a|, quotient = all ones.
              state_d = S_FIXUP;
              acc_d   = {mag_a, {DATA_W{1'b1}}};
              neg_d   = 1'b0;
              zdiv_d  = 1'b1;
            end
          end else begin
            opnd_d = mag_a;
            acc_d  = {{DATA_W{1'b0}}, mag_b};
          end
        end
      end
      S_CALC: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = CNT_W'(cnt_q + 1'b1);
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = S_FIXUP;
      end
      S_FIXUP: begin
        state_d = S_DONE;
        if (is_div_q) begin
          hi_d = sign_a_q ? rem_neg : acc_q[ACC_W-1:DATA_W];
          lo_d = neg_q ? quo_neg : acc_q[DATA_W-1:0];
        end else begin
          {hi_d, lo_d} = neg_q ? prod_neg : acc_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_CALC) || (state_d == S_FIXUP);
    done_d = (state_d == S_DONE);
    dbz_d  = (state_d == S_DONE) && zdiv_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      neg_q    <= 1'b0;
      zdiv_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dbz      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      sign_a_q <= sign_a_d;
      neg_q    <= neg_d;
      zdiv_q   <= zdiv_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy     <= busy_d;
      done     <= done_d;
      dbz      <= dbz_d;
    end
  end

endmodule

// File: tb/tb_hilo_md_sequencer.sv
// Directed self-checking bench for hilo_md_sequencer: vector table of ops plus
// hand-written stall, MTLO and mid-operation reset sequences.
module tb_hilo_md_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b, wd;
  logic        wr_hi, wr_lo, rd_req;
  logic [31:0] hi_q, lo_q;
  logic        busy, done, dbz, stall;

  int checks = 0;
  int errors = 0;

  hilo_md_sequencer #(.DATA_W(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wd(wd), .rd_req(rd_req),
    .hi_q(hi_q), .lo_q(lo_q), .busy(busy), .done(done), .dbz(dbz), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one op, measure busy/latency, check result and one-cycle done.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] va,
                        input logic [31:0] vb, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edbz);
    int lat, bcnt, exp_lat;
    logic seen;
    start = 1'b1; op = o; a = va; b = vb;
    tick();
    start = 1'b0;
    lat = 0; bcnt = 0; seen = 1'b0;
    exp_lat = edbz ? 1 : 33;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) bcnt++;
      tick();
      lat++;
    end
    check({name, " done_seen"}, 64'(seen), 64'd1);
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " busy_cycles"}, 64'(bcnt), 64'(exp_lat));
    check({name, " hi"}, 64'(hi_q), 64'(ehi));
    check({name, " lo"}, 64'(lo_q), 64'(elo));
    check({name, " dbz"}, 64'(dbz), 64'(edbz));
    tick();
    check({name, " done_one_cycle"}, 64'(done), 64'd0);
  endtask

  initial begin
    int n;
    logic seen;

    vecs[0] = '{"multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1] = '{"mult_neg",  2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[2] = '{"div_neg",   2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3] = '{"div_ovf",   2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[4] = '{"divu_zero", 2'b10, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1};
    vecs[5] = '{"div_zero",  2'b11, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vecs[6] = '{"mult_pos",  2'b01, 32'h00001234, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFDB98, 1'b0};
    vecs[7] = '{"divu_100",  2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};

    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    wr_hi = 1'b0; wr_lo = 1'b0; wd = '0; rd_req = 1'b0;
    #2;
    check("reset hi", 64'(hi_q), 64'd0);
    check("reset lo", 64'(lo_q), 64'd0);
    check("reset flags", 64'({busy, done, dbz, stall}), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dbz);

    // MTLO while idle: HI stays at the last DIVU remainder.
    wr_lo = 1'b1; wd = 32'hCAFEBABE;
    #1;
    check("mtlo stall", 64'(stall), 64'd0);
    tick();
    wr_lo = 1'b0;
    check("mtlo lo", 64'(lo_q), 64'hCAFEBABE);
    check("mtlo hi", 64'(hi_q), 64'd2);

    // Requests held during a running MULTU are stalled and ignored.
    start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd6;
    tick();
    op = 2'b10; a = 32'd100; b = 32'd7;
    rd_req = 1'b1; wr_hi = 1'b1; wd = 32'h1234;
    #1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) begin
        check("hold stall", 64'(stall), 64'd1);
        check("hold hilo", {hi_q, lo_q}, {32'd2, 32'hCAFEBABE});
      end
      tick();
    end
    check("hold done_seen", 64'(seen), 64'd1);
    check("hold done stall", 64'(stall), 64'd0);
    check("hold result", {hi_q, lo_q}, {32'd0, 32'd30});
    tick();
    start = 1'b0; rd_req = 1'b0; wr_hi = 1'b0;
    check("second start busy", 64'(busy), 64'd1);
    check("second start mthi", 64'(hi_q), 64'h1234);
    n = 0; seen = 1'b0;
    while (n < 100 && !seen) begin
      tick();
      n++;
      seen = done;
    end
    check("second op done", 64'(seen), 64'd1);
    check("second op result", {hi_q, lo_q}, {32'd2, 32'd14});
    tick();

    // Reset pulsed mid-CALC discards the partial result immediately.
    start = 1'b1; op = 2'b00; a = 32'h1234; b = 32'h55;
    tick();
    start = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    #1;
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst hilo", {hi_q, lo_q}, 64'd0);
    check("midrst done", 64'(done), 64'd0);
    #1;
    rst = 1'b0;
    tick();
    run_op("multu_3x4", 2'b00, 32'd3, 32'd4, 32'd0, 32'h0000000C, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
